// File: rtl/sseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sseg_scan_ctrl
// Brief    : Time-multiplexed scan controller for a common-anode 7-segment
//            display. Per-digit register file and one shared num2sseg decoder.
//            Optional build macro LEADING_ZERO_BLANK_EN darkens leading zeros.
// Revision : 1.0  initial release
// ============================================================================
module sseg_scan_ctrl #(
    parameter int N_DIGITS = 4,
    parameter int DIV      = 100000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [$clog2(N_DIGITS)-1:0] wr_idx,
    input  logic [3:0]                  wr_data,
    input  logic                        wr_dp,
    input  logic [N_DIGITS-1:0]         blank_mask,
    output logic [N_DIGITS-1:0]         an,
    output logic [6:0]                  sseg,
    output logic                        dp,
    output logic                        digit_tick
);

    localparam int c_IW = $clog2(N_DIGITS);
    localparam int c_PW = $clog2(DIV);

    // Scan states S0..S{N-1}: the state is the digit index itself.
    localparam logic [c_IW-1:0] c_S0    = '0;
    localparam logic [c_IW-1:0] c_SLAST = c_IW'(N_DIGITS - 1);

    logic [c_PW-1:0]     r_presc;
    logic                w_tc;
    logic [c_IW-1:0]     r_idx;
    logic [c_IW-1:0]     w_idx_nxt;
    logic [3:0]          r_val [N_DIGITS];
    logic [N_DIGITS-1:0] r_dpv;
    logic                w_wr_ok;
    logic [N_DIGITS-1:0] w_lzb;
    logic                w_blank;
    logic [N_DIGITS-1:0] w_an;
    logic [6:0]          w_sseg;
    logic                w_dp;

    function automatic logic [6:0] num2sseg(input logic [3:0] v);
        case (v)
            4'd0:    num2sseg = 7'b1000000;
            4'd1:    num2sseg = 7'b1111001;
            4'd2:    num2sseg = 7'b0100100;
            4'd3:    num2sseg = 7'b0110000;
            4'd4:    num2sseg = 7'b0011001;
            4'd5:    num2sseg = 7'b0010010;
            4'd6:    num2sseg = 7'b0000010;
            4'd7:    num2sseg = 7'b1111000;
            4'd8:    num2sseg = 7'b0000000;
            4'd9:    num2sseg = 7'b0010000;
            default: num2sseg = 7'h7F;
        endcase
    endfunction

    assign w_tc = (r_presc == c_PW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc    <= '0;
            digit_tick <= 1'b0;
        end else begin
            r_presc    <= w_tc ? '0 : r_presc + c_PW'(1);
            digit_tick <= w_tc;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx <= c_S0;
        end else begin
            r_idx <= w_idx_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_idx_nxt = r_idx;
        if (w_tc) begin
            w_idx_nxt = (r_idx == c_SLAST) ? c_S0 : r_idx + c_IW'(1);
        end
    end

    // Out-of-range indices (possible only for non power-of-two N) are dropped.
    assign w_wr_ok = wr_en && (int'(wr_idx) < N_DIGITS);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                r_val[i] <= 4'd0;
            end
            r_dpv <= '0;
        end else if (w_wr_ok) begin
            r_val[wr_idx] <= wr_data;
            r_dpv[wr_idx] <= wr_dp;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic w_run;
    // Walk down from the most significant digit; digit 0 always stays lit.
    always_comb begin
        w_lzb = '0;
        w_run = 1'b1;
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            w_run    = w_run && (r_val[i] == 4'd0);
            w_lzb[i] = w_run;
        end
    end
`else
    assign w_lzb = '0;
`endif

    // Output logic
    always_comb begin
        w_blank = blank_mask[r_idx] | w_lzb[r_idx];
        w_an    = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            w_an[i] = ~((r_idx == c_IW'(i)) && !w_blank);
        end
        w_sseg = w_blank ? 7'h7F : num2sseg(r_val[r_idx]);
        w_dp   = w_blank ? 1'b1 : ~r_dpv[r_idx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            an   <= '1;
            sseg <= 7'h7F;
            dp   <= 1'b1;
        end else begin
            an   <= w_an;
            sseg <= w_sseg;
            dp   <= w_dp;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sseg_scan_ctrl
// Brief    : Scoreboard bench for sseg_scan_ctrl (N_DIGITS=4, DIV=4) with a
//            time-based reference model; honours LEADING_ZERO_BLANK_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_sseg_scan_ctrl;

    localparam int c_N   = 4;
    localparam int c_DIV = 4;

    typedef struct packed {
        logic [c_N-1:0] an;
        logic [6:0]     sseg;
        logic           dp;
        logic           tick;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           wr_en;
    logic [1:0]     wr_idx;
    logic [3:0]     wr_data;
    logic           wr_dp;
    logic [c_N-1:0] blank_mask;
    logic [c_N-1:0] an;
    logic [6:0]     sseg;
    logic           dp;
    logic           digit_tick;

    sseg_scan_ctrl #(.N_DIGITS(c_N), .DIV(c_DIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data),
        .wr_dp      (wr_dp),
        .blank_mask (blank_mask),
        .an         (an),
        .sseg       (sseg),
        .dp         (dp),
        .digit_tick (digit_tick)
    );

    always #5 clk = ~clk;

    exp_t q_exp[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference state: edges elapsed since reset plus the stored digits.
    int   m_k;
    int   m_val [c_N];
    bit   m_dp  [c_N];

    function automatic logic [6:0] seg_of(input int v);
        logic [6:0] t [10];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return (v < 10) ? t[v] : 7'h7F;
    endfunction

    function automatic exp_t model_out(input logic [c_N-1:0] mask);
        exp_t e;
        int   d;
        bit   dark;
        int   top;
        d    = (m_k / c_DIV) % c_N;
        dark = mask[d];
`ifdef LEADING_ZERO_BLANK_EN
        top = 0;
        for (int i = c_N - 1; i >= 0; i--) begin
            if (m_val[i] != 0 && top == 0) top = i;
        end
        if (d > top) dark = 1'b1;
`else
        top = 0;
`endif
        e.an   = dark ? '1 : ~(c_N'(1) << d);
        e.sseg = dark ? 7'h7F : seg_of(m_val[d]);
        e.dp   = dark ? 1'b1 : ~m_dp[d];
        e.tick = ((m_k % c_DIV) == c_DIV - 1);
        return e;
    endfunction

    task automatic drive(input bit rst, input bit we, input int idx, input int data,
                         input bit wdp, input logic [c_N-1:0] mask);
        exp_t e;
        reset      = rst;
        wr_en      = we;
        wr_idx     = 2'(idx);
        wr_data    = 4'(data);
        wr_dp      = wdp;
        blank_mask = mask;
        if (rst) begin
            e = '{an: '1, sseg: 7'h7F, dp: 1'b1, tick: 1'b0};
            m_k = 0;
            for (int i = 0; i < c_N; i++) begin
                m_val[i] = 0;
                m_dp[i]  = 1'b0;
            end
        end else begin
            e = model_out(mask);
            if (we && idx < c_N) begin
                m_val[idx] = data;
                m_dp[idx]  = wdp;
            end
            m_k++;
        end
        q_exp.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic [c_N-1:0] mask);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 1'b0, mask);
    endtask

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    // Monitor: the DUT presents a fresh output word after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                check("an",         int'(an),         int'(e.an));
                check("sseg",       int'(sseg),       int'(e.sseg));
                check("dp",         int'(dp),         int'(e.dp));
                check("digit_tick", int'(digit_tick), int'(e.tick));
            end
        end
    end

    initial begin
        int ticks;
        m_k = 0;
        drive(1'b1, 1'b0, 0, 0, 1'b0, '0);
        drive(1'b1, 1'b0, 0, 0, 1'b0, '0);
        for (int i = 0; i < c_N; i++) drive(1'b0, 1'b1, i, i + 1, 1'b0, '0);
        idle(16, '0);
        ticks = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 0, 0, 1'b0, '0);
            ticks += int'(digit_tick);
        end
        check("tick_count_16", ticks, 4);
        drive(1'b0, 1'b1, 1, 11, 1'b1, '0);
        idle(16, '0);
        idle(16, 4'b0100);
        while (((m_k / c_DIV) % c_N) != 2) drive(1'b0, 1'b0, 0, 0, 1'b0, '0);
        drive(1'b0, 1'b0, 0, 0, 1'b0, '0);
        drive(1'b1, 1'b0, 0, 0, 1'b0, '0);
        idle(8, '0);
        drive(1'b0, 1'b1, 3, 0, 1'b0, '0);
        drive(1'b0, 1'b1, 2, 5, 1'b0, '0);
        drive(1'b0, 1'b1, 1, 0, 1'b1, '0);
        drive(1'b0, 1'b1, 0, 0, 1'b0, '0);
        idle(20, '0);
        drive(1'b0, 1'b1, 3, 7, 1'b0, '0);
        idle(20, '0);
        for (int c = 0; c < 1500; c++) begin
            bit             rst;
            bit             we;
            logic [c_N-1:0] mask;
            rst  = ($urandom_range(99) == 0);
            we   = ($urandom_range(3) == 0);
            mask = ($urandom_range(3) == 0) ? c_N'($urandom) : '0;
            drive(rst, we, $urandom_range(c_N - 1),
                  ($urandom_range(1) == 0) ? $urandom_range(9) : $urandom_range(15),
                  1'($urandom), mask);
        end
        #5;
        check("queue_drained", q_exp.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
